// File: rtl/btn_pulse_pkg.sv
// rtl/btn_pulse_pkg.sv - shared types and default constants for the button conditioner
package btn_pulse_pkg;

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} chan_state_t;

  localparam int DEF_N_BTN      = 2;
  localparam int DEF_TICK_DIV   = 131072;
  localparam int DEF_STABLE_CNT = 8;
  localparam int DEF_REPEAT_DLY = 384;
  localparam int DEF_REPEAT_PER = 96;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_pulse_gen_if.sv
// rtl/btn_pulse_gen_if.sv - raw button levels in, debounced levels and step pulses out
interface btn_pulse_gen_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] BTN;
  logic [N_BTN-1:0] LEVEL;
  logic [N_BTN-1:0] PULSE;

  modport master (output BTN, input LEVEL, input PULSE);
  modport slave  (input BTN, output LEVEL, output PULSE);
endinterface

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button: 2-flop synchroniser, tick-based debounce, press/repeat FSM
module btn_chan
  import btn_pulse_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int STAB_W = $clog2(STABLE_CNT + 1);
  localparam int REP_W  = $clog2(max2(REPEAT_DLY, REPEAT_PER) + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [REP_W-1:0]  DLY_LAST  = REP_W'((REPEAT_DLY == 0) ? 0 : REPEAT_DLY - 1);
  localparam logic [REP_W-1:0]  PER_LAST  = REP_W'(REPEAT_PER - 1);

  logic              sync1;
  logic              sample;
  logic [STAB_W-1:0] stab_cnt;
  logic [REP_W-1:0]  rep_cnt;
  chan_state_t       state;
  logic              toggle;
  logic              rise;
  logic              fall;

  // The FSM reacts on the same edge the debounced level changes.
  assign toggle = tick && (sample != level) && (stab_cnt == STAB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1    <= 1'b0;
      sample   <= 1'b0;
      stab_cnt <= '0;
      rep_cnt  <= '0;
      level    <= 1'b0;
      pulse    <= 1'b0;
      state    <= IDLE;
    end else begin
      sync1  <= btn;
      sample <= sync1;
      pulse  <= 1'b0;

      if (tick) begin
        if (sample != level) begin
          if (stab_cnt == STAB_LAST) begin
            level    <= ~level;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end else begin
          stab_cnt <= '0;
        end
      end

      case (state)
        IDLE: begin
          if (rise) begin
            pulse   <= 1'b1;
            rep_cnt <= '0;
            state   <= HELD;
          end
        end
        HELD: begin
          // Release wins over a repeat falling due on the same tick.
          if (fall) begin
            state <= IDLE;
          end else if (tick && REPEAT_DLY != 0) begin
            if (rep_cnt == DLY_LAST) begin
              pulse   <= 1'b1;
              rep_cnt <= '0;
              state   <= REPEAT;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
        REPEAT: begin
          if (fall) begin
            state <= IDLE;
          end else if (tick) begin
            if (rep_cnt == PER_LAST) begin
              pulse   <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - shared sample-tick prescaler feeding N_BTN independent button channels
module btn_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
) (
  input logic           CLK,
  input logic           RST,
  btn_pulse_gen_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc;
  logic             tick;

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .STABLE_CNT(STABLE_CNT),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    ) u_chan (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .btn  (bus.BTN[i]),
      .level(bus.LEVEL[i]),
      .pulse(bus.PULSE[i])
    );
  end

endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

Per-button input conditioner feeding the LED pattern controller's UP/DOWN step inputs. Synchronises raw push-button levels, debounces them on a shared slow sample tick, and emits one-CLK-cycle step pulses on press with optional hold-to-auto-repeat. It sits between the board button pins and the pattern-select logic, so the pattern controller sees only clean, single-cycle events.

## Interface
- N_BTN, 2, number of independent button channels
- TICK_DIV, 131072, CLK cycles per sample tick (≥2)
- STABLE_CNT, 8, consecutive differing samples required to change debounced level (≥1)
- REPEAT_DLY, 384, ticks from accepted press to first repeat pulse; 0 disables auto-repeat
- REPEAT_PER, 96, ticks between subsequent repeat pulses (≥1)

- CLK  in  1  system clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- BTN  in  N_BTN  raw button levels, asynchronous, active-high
- LEVEL  out  N_BTN  debounced button level
- PULSE  out  N_BTN  one-cycle step pulse per press / repeat

## Operation
- Reset (RST=0): prescaler, synchronisers, counters, state cleared; LEVEL=0, PULSE=0, all channels IDLE.
- Synchroniser: 2 flops per bit; sample = second flop.
- Prescaler: counts 0..TICK_DIV-1, wraps; tick = (prescaler == TICK_DIV-1), shared by all channels.
- Debounce per channel, on tick only: sample != LEVEL → stab_cnt+1; sample == LEVEL → stab_cnt=0. When sample != LEVEL and stab_cnt == STABLE_CNT-1: LEVEL toggles, stab_cnt=0.
- Per-channel FSM (states in package): IDLE, HELD, REPEAT.
  - IDLE: LEVEL rising → PULSE=1 same edge, rep_cnt=0, → HELD.
  - HELD: each tick rep_cnt+1; REPEAT_DLY≠0 and rep_cnt reaches REPEAT_DLY → PULSE, rep_cnt=0, → REPEAT.
  - REPEAT: each tick rep_cnt+1; reaching REPEAT_PER → PULSE, rep_cnt=0.
  - HELD/REPEAT: LEVEL falling → IDLE, no pulse. Release takes priority over a repeat due on the same tick.
- Channels fully independent; simultaneous presses give simultaneous pulses.
- Counter widths: $clog2 of respective max (+1); no counter overflows.

## Timing
- PULSE high exactly one CLK cycle, registered, coincident with first cycle LEVEL=1 (press pulse) or the cycle after the due tick (repeat pulse).
- Press latency: 2 sync cycles + STABLE_CNT ticks, phase-dependent on prescaler (max 2 + STABLE_CNT·TICK_DIV cycles).
- Glitches shorter than STABLE_CNT consecutive ticks produce no LEVEL change and no pulse.
- Reset mid-press: outputs drop asynchronously; if BTN still held after release of RST, a fresh press is re-accepted after the normal debounce latency.
- Reset release is taken synchronously to CLK (reset-release synchroniser is outside this block).

## Structure
- Package btn_pulse_pkg: FSM state enum (IDLE, HELD, REPEAT), default parameter constants.
- Sub-module btn_chan: synchroniser + debounce + FSM for one bit; btn_pulse_gen instantiates N_BTN of them plus the shared prescaler.

## Test plan
Parameters for all: TICK_DIV=4, STABLE_CNT=3, REPEAT_DLY=5, REPEAT_PER=2; cycle 0 = first edge after RST release; ticks at cycles 3, 7, 11, …
- Clean press: BTN[0]=1 from cycle 0, held → LEVEL[0] and PULSE[0] rise at cycle 12; PULSE[0] low at cycle 13; BTN[1] channel stays 0.
- Auto-repeat: continue hold → further single-cycle PULSE[0] at cycles 32, 40, 48; release → LEVEL[0] falls 3 ticks later, no pulse on release.
- Glitch reject: BTN[0] high for 6 cycles only → LEVEL[0]=0 and PULSE[0]=0 throughout.
- Bounce: BTN[0] toggling every 3 cycles for 30 cycles then steady 1 → exactly one press pulse, LEVEL[0] rises exactly 3 ticks after the sampled level last changed.
- Simultaneous: BTN=2'b11 from cycle 0 → PULSE=2'b11 at cycle 12, repeats aligned on both bits.
- Reset mid-hold: RST=0 at cycle 20 for 3 cycles with BTN[0] held → PULSE/LEVEL=0 immediately; press pulse again after re-debounce (cycle 12 relative to new cycle 0). REPEAT_DLY=0 variant: held button gives exactly one pulse.
